pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard and pipeline-control unit for the 5-stage (IF/ID/EX/MEM/WB) core. It replaces the ad-hoc stall/flush/forward logic with a single block. The block keeps its own shadow copy of in-flight destination writes and generates load-use interlocks, branch flushes, global freeze, forwarding selects and a halt-drain state machine. It sits beside the pipeline registers in the CPU top and drives their enable/clear inputs.

## Interface
- REG_AW, 4: register-address width; register 0 is hard-zero and never matches.
- CNT_W, 32: performance-counter width (used only with PIPE_HAZARD_CTRL_PERF_EN).
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_src0_addr, id_src1_addr  in  REG_AW  ID source registers
- id_src0_used, id_src1_used  in  1  source actually read
- id_dst_addr  in  REG_AW  ID destination
- id_reg_we, id_mem_re, id_hlt  in  1  ID decode flags
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- cache_stall  in  1  memory hierarchy busy
- freeze  out  1  hold every pipeline register (= cache_stall)
- stall_front  out  1  hold PC and IF/ID; insert bubble into ID/EX
- flush_if_id, flush_id_ex  out  1  clear those registers on next edge
- fetch_en  out  1  PC may advance
- fwd_sel0, fwd_sel1  out  2  EX operand source: 0 regfile, 1 EX/MEM, 2 MEM/WB, 3 WB bypass
- halted  out  1  halt instruction has retired
- cnt_retired, cnt_stall, cnt_flush  out  CNT_W  (macro only)

## Operation
- Shadow entries EX, MEM, WB, WB1 each hold {valid, dst, we, mem_re, hlt}. On every edge with freeze=0 they shift one stage toward WB1. EX loads the ID fields, or a bubble (valid=0) when stall_front or a flush is active.
- Load-use: stall_front=1 when EX.valid & EX.mem_re & EX.we & EX.dst!=0 & id_valid & (used source matches EX.dst).
- Branch: branch_taken asserts flush_if_id and flush_id_ex, and suppresses stall_front.
- Priority: freeze > branch flush > load-use stall. While frozen, all shadow state and the FSM hold, and flush/stall outputs still reflect their conditions; the pipeline ignores them under freeze.
- fwd_selN, evaluated for the EX entry's registered sources, picks the first match in this order:
  - MEM (we, !mem_re, dst match): 1
  - WB: 2
  - WB1: 3
  - otherwise 0
  - A source equal to 0 always gets 0.
- Halt FSM states RUN, DRAIN, HALTED:
  - RUN→DRAIN when id_valid & id_hlt & !branch_taken & !freeze; fetch_en=0 from then on.
  - DRAIN→RUN if branch_taken, because an older branch flushed the halt.
  - DRAIN→HALTED when the WB entry has hlt=1.
  - HALTED is sticky until reset: fetch_en=0, halted=1.

## Timing
- Reset values:
  - Shadow entries invalid.
  - FSM=RUN, fetch_en=1, halted=0, counters=0.
  - stall_front=0, flush_*=0, fwd_sel*=0.
- stall_front, flush_*, fwd_sel*, freeze are combinational from shadow state and current inputs, with no added latency. halted and fetch_en are registered.
- A load-use stall lasts exactly 1 cycle, longer only if frozen. The consumer then reaches EX with fwd_sel=2.
- A taken branch produces exactly 2 bubbles.
- cache_stall mid-stall extends the stall; the EX bubble is inserted only on the unfrozen edge.
- Reset asserted mid-drain returns to RUN immediately.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined:
  - cnt_retired increments when WB.valid & !freeze.
  - cnt_stall increments per cycle of stall_front|freeze.
  - cnt_flush increments per branch_taken & !freeze.
  - All three saturate at all-ones and stop counting in HALTED.
- Undefined: the counter ports and logic are absent.

## Structure
- pipe_ctrl_pkg: fwd_sel_e (FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_WB), halt_state_e, shadow_entry_t struct.
- Sub-module pipe_perf_counters (three saturating counters), instantiated only under the macro.

## Test plan
- Load R3 in EX, ID adds R3+R4 → stall_front=1 for 1 cycle; consumer in EX gets fwd_sel0=2.
- ADD R5 then ADD R6=R5+R5 back-to-back → no stall; fwd_sel0=fwd_sel1=1.
- Writer of R2, two independent instrs, reader of R2 → fwd_sel=3. A write to R0 followed by a read of R0 → fwd_sel=0.
- branch_taken with a load-use condition present → flush_if_id=flush_id_ex=1, stall_front=0; 2 bubbles reach WB.
- cache_stall held 4 cycles during a load-use stall → shadow state unchanged; stall resolves 1 cycle after release.
- HLT in ID with no branch → fetch_en=0 next cycle, halted=1 three cycles later. Same case with branch_taken in DRAIN → FSM returns to RUN, halted stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/control unit: forwarding selects,
// halt FSM states and the shadow-entry record tracking in-flight writes.
package pipe_ctrl_pkg;

  // Shadow destinations are stored at this fixed width; REG_AW must not exceed it.
  localparam int DST_W = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2,
    FWD_WB    = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2
  } halt_state_e;

  typedef struct packed {
    logic             valid;
    logic [DST_W-1:0] dst;
    logic             we;
    logic             mem_re;
    logic             hlt;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '0;

  function automatic logic entry_writes(input shadow_entry_t e, input logic [DST_W-1:0] r);
    return e.valid & e.we & (e.dst == r);
  endfunction

  // Youngest producer wins; a load still in MEM has no data to forward yet.
  function automatic fwd_sel_e fwd_pick(input logic [DST_W-1:0] src,
                                        input shadow_entry_t mem_e,
                                        input shadow_entry_t wb_e,
                                        input shadow_entry_t wb1_e);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (entry_writes(mem_e, src) && !mem_e.mem_re) begin
        sel = FWD_EXMEM;
      end else if (entry_writes(wb_e, src)) begin
        sel = FWD_MEMWB;
      end else if (entry_writes(wb1_e, src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_perf_counters.sv
// Three saturating event counters (retired, stall cycles, flushes) that
// stop counting once the core has halted.
module pipe_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halted_i,
  input  logic             retire_inc_i,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] cnt_retired_o,
  output logic [CNT_W-1:0] cnt_stall_o,
  output logic [CNT_W-1:0] cnt_flush_o
);

  logic [2:0]         inc;
  logic [3*CNT_W-1:0] cnt_flat;

  assign inc = {flush_inc_i, stall_inc_i, retire_inc_i};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (inc[gi] && !halted_i && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate

  assign cnt_retired_o = cnt_flat[0*CNT_W +: CNT_W];
  assign cnt_stall_o   = cnt_flat[1*CNT_W +: CNT_W];
  assign cnt_flush_o   = cnt_flat[2*CNT_W +: CNT_W];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core: load-use interlock,
// branch flush, freeze, forwarding selects and halt drain. Optional performance
// counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src0_addr,
  input  logic [REG_AW-1:0] id_src1_addr,
  input  logic              id_src0_used,
  input  logic              id_src1_used,
  input  logic [REG_AW-1:0] id_dst_addr,
  input  logic              id_reg_we,
  input  logic              id_mem_re,
  input  logic              id_hlt,
  input  logic              branch_taken,
  input  logic              cache_stall,
  output logic              freeze,
  output logic              stall_front,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              fetch_en,
  output logic [1:0]        fwd_sel0,
  output logic [1:0]        fwd_sel1,
  output logic              halted
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  cnt_retired,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_flush
`endif
);

  shadow_entry_t    ex_q, mem_q, wb_q, wb1_q;
  shadow_entry_t    ex_d;
  logic [DST_W-1:0] ex_src0_q, ex_src1_q;
  logic [DST_W-1:0] ex_src0_d, ex_src1_d;
  logic [DST_W-1:0] id_src0_w, id_src1_w;
  logic             load_use;
  logic             ex_bubble;

  halt_state_e      state_q, state_d;
  logic             fetch_en_q, fetch_en_d;
  logic             halted_q, halted_d;

  assign id_src0_w = DST_W'(id_src0_addr);
  assign id_src1_w = DST_W'(id_src1_addr);

  assign load_use = ex_q.valid & ex_q.mem_re & ex_q.we & (ex_q.dst != '0) & id_valid &
                    ((id_src0_used & (id_src0_w == ex_q.dst)) |
                     (id_src1_used & (id_src1_w == ex_q.dst)));

  assign freeze      = cache_stall;
  assign flush_if_id = branch_taken;
  assign flush_id_ex = branch_taken;
  assign stall_front = load_use & ~branch_taken;

  assign fwd_sel0 = fwd_pick(ex_src0_q, mem_q, wb_q, wb1_q);
  assign fwd_sel1 = fwd_pick(ex_src1_q, mem_q, wb_q, wb1_q);

  // Bubbles carry zero sources so an empty EX never requests forwarding.
  assign ex_bubble = stall_front | branch_taken | ~id_valid;

  always_comb begin
    ex_d      = SHADOW_BUBBLE;
    ex_src0_d = '0;
    ex_src1_d = '0;
    if (!ex_bubble) begin
      ex_d.valid  = 1'b1;
      ex_d.dst    = DST_W'(id_dst_addr);
      ex_d.we     = id_reg_we;
      ex_d.mem_re = id_mem_re;
      ex_d.hlt    = id_hlt;
      ex_src0_d   = id_src0_w;
      ex_src1_d   = id_src1_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= SHADOW_BUBBLE;
      mem_q     <= SHADOW_BUBBLE;
      wb_q      <= SHADOW_BUBBLE;
      wb1_q     <= SHADOW_BUBBLE;
      ex_src0_q <= '0;
      ex_src1_q <= '0;
    end else if (!freeze) begin
      ex_q      <= ex_d;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      wb1_q     <= wb_q;
      ex_src0_q <= ex_src0_d;
      ex_src1_q <= ex_src1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!freeze) begin
      case (state_q)
        ST_RUN: begin
          if (id_valid && id_hlt && !branch_taken) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // An older taken branch squashes the halt still in flight.
          if (branch_taken) begin
            state_d = ST_RUN;
          end else if (wb_q.valid && wb_q.hlt) begin
            state_d = ST_HALTED;
          end
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_RUN;
      endcase
    end
    fetch_en_d = (state_d == ST_RUN);
    halted_d   = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_en_q <= 1'b1;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_en_q <= fetch_en_d;
      halted_q   <= halted_d;
    end
  end

  assign fetch_en = fetch_en_q;
  assign halted   = halted_q;

  logic unused_shadow_bits;
  assign unused_shadow_bits = ^{ex_q.hlt, mem_q.hlt, wb_q.mem_re, wb1_q.mem_re, wb1_q.hlt};

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  pipe_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .halted_i      (state_q == ST_HALTED),
    .retire_inc_i  (wb_q.valid & ~freeze),
    .stall_inc_i   (stall_front | freeze),
    .flush_inc_i   (branch_taken & ~freeze),
    .cnt_retired_o (cnt_retired),
    .cnt_stall_o   (cnt_stall),
    .cnt_flush_o   (cnt_flush)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus a
// randomized run checked against an age-ordered history model of in-flight writes.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_src0_addr, id_src1_addr, id_dst_addr;
  logic       id_src0_used, id_src1_used;
  logic       id_reg_we, id_mem_re, id_hlt;
  logic       branch_taken, cache_stall;
  logic       freeze, stall_front, flush_if_id, flush_id_ex, fetch_en, halted;
  logic [1:0] fwd_sel0, fwd_sel1;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] cnt_retired, cnt_stall, cnt_flush;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(4), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src0_addr (id_src0_addr),
    .id_src1_addr (id_src1_addr),
    .id_src0_used (id_src0_used),
    .id_src1_used (id_src1_used),
    .id_dst_addr  (id_dst_addr),
    .id_reg_we    (id_reg_we),
    .id_mem_re    (id_mem_re),
    .id_hlt       (id_hlt),
    .branch_taken (branch_taken),
    .cache_stall  (cache_stall),
    .freeze       (freeze),
    .stall_front  (stall_front),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .fetch_en     (fetch_en),
    .fwd_sel0     (fwd_sel0),
    .fwd_sel1     (fwd_sel1),
    .halted       (halted)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .cnt_retired  (cnt_retired),
    .cnt_stall    (cnt_stall),
    .cnt_flush    (cnt_flush)
`endif
  );

  // Instructions that entered EX, youngest first: index = age in stages past EX.
  typedef struct { bit v; int dst; bit we; bit mre; int s0; int s1; } ent_t;
  ent_t hist[$];

  task automatic idle_inputs();
    id_valid = 0; id_src0_addr = 0; id_src1_addr = 0; id_src0_used = 0; id_src1_used = 0;
    id_dst_addr = 0; id_reg_we = 0; id_mem_re = 0; id_hlt = 0;
  endtask

  task automatic drive_id(input int s0, input bit u0, input int s1, input bit u1,
                          input int dst, input bit we, input bit mre, input bit hlt);
    id_valid = 1; id_src0_addr = 4'(s0); id_src0_used = u0; id_src1_addr = 4'(s1);
    id_src1_used = u1; id_dst_addr = 4'(dst); id_reg_we = we; id_mem_re = mre; id_hlt = hlt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; idle_inputs(); branch_taken = 0; cache_stall = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs(); branch_taken = 0; cache_stall = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (fetch_en !== 1'b1) begin n_bad++; $display("FAIL rst_fetch_en: got %b want 1", fetch_en); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_cmp++; if ({stall_front, flush_if_id, flush_id_ex, freeze} !== 4'b0) begin n_bad++; $display("FAIL rst_ctrl: got %b want 0000", {stall_front, flush_if_id, flush_id_ex, freeze}); end
    n_cmp++; if ({fwd_sel0, fwd_sel1} !== 4'b0) begin n_bad++; $display("FAIL rst_fwd: got %0d/%0d want 0/0", fwd_sel0, fwd_sel1); end
    rst_n = 1;
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk); drive_id(0, 0, 0, 0, 3, 1, 1, 0); #1;
    n_cmp++; if (stall_front !== 1'b0) begin n_bad++; $display("FAIL lu_pre: got %b want 0", stall_front); end
    @(negedge clk); drive_id(3, 1, 4, 1, 7, 1, 0, 0); #1;
    n_cmp++; if (stall_front !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", stall_front); end
    @(negedge clk); #1;
    n_cmp++; if (stall_front !== 1'b0) begin n_bad++; $display("FAIL lu_one_cycle: got %b want 0", stall_front); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (fwd_sel0 !== 2'd2) begin n_bad++; $display("FAIL lu_fwd0: got %0d want 2", fwd_sel0); end
    n_cmp++; if (fwd_sel1 !== 2'd0) begin n_bad++; $display("FAIL lu_fwd1: got %0d want 0", fwd_sel1); end
    $display("test_load_use done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk); drive_id(1, 1, 2, 1, 5, 1, 0, 0);
    @(negedge clk); drive_id(5, 1, 5, 1, 6, 1, 0, 0); #1;
    n_cmp++; if (stall_front !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got %b want 0", stall_front); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (fwd_sel0 !== 2'd1) begin n_bad++; $display("FAIL b2b_fwd0: got %0d want 1", fwd_sel0); end
    n_cmp++; if (fwd_sel1 !== 2'd1) begin n_bad++; $display("FAIL b2b_fwd1: got %0d want 1", fwd_sel1); end
    $display("test_back_to_back done");
  endtask

  task automatic test_fwd_wb1_r0();
    do_reset();
    @(negedge clk); drive_id(0, 0, 0, 0, 2, 1, 0, 0);
    @(negedge clk); drive_id(9, 1, 10, 1, 8, 1, 0, 0);
    @(negedge clk); drive_id(12, 1, 13, 1, 11, 1, 0, 0);
    @(negedge clk); drive_id(2, 1, 0, 1, 14, 1, 0, 0);
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (fwd_sel0 !== 2'd3) begin n_bad++; $display("FAIL wb1_fwd0: got %0d want 3", fwd_sel0); end
    n_cmp++; if (fwd_sel1 !== 2'd0) begin n_bad++; $display("FAIL wb1_fwd1: got %0d want 0", fwd_sel1); end
    @(negedge clk); drive_id(0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk); drive_id(0, 1, 0, 1, 4, 1, 0, 0); #1;
    n_cmp++; if (stall_front !== 1'b0) begin n_bad++; $display("FAIL r0_stall: got %b want 0", stall_front); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if ({fwd_sel0, fwd_sel1} !== 4'b0) begin n_bad++; $display("FAIL r0_fwd: got %0d/%0d want 0/0", fwd_sel0, fwd_sel1); end
    $display("test_fwd_wb1_r0 done");
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk); drive_id(0, 0, 0, 0, 3, 1, 1, 0);
    @(negedge clk); drive_id(3, 1, 4, 1, 3, 1, 0, 0); branch_taken = 1; #1;
    n_cmp++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin n_bad++; $display("FAIL br_flush: got %b want 11", {flush_if_id, flush_id_ex}); end
    n_cmp++; if (stall_front !== 1'b0) begin n_bad++; $display("FAIL br_stall: got %b want 0", stall_front); end
    @(negedge clk); idle_inputs(); branch_taken = 0; #1;
    n_cmp++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin n_bad++; $display("FAIL br_flush_end: got %b want 00", {flush_if_id, flush_id_ex}); end
    @(negedge clk); drive_id(3, 1, 0, 0, 9, 1, 0, 0); #1;
    n_cmp++; if (stall_front !== 1'b0) begin n_bad++; $display("FAIL br_nostall: got %b want 0", stall_front); end
    @(negedge clk); idle_inputs(); #1;
    // Two bubbles between the load and the reader put the load in WB1.
    n_cmp++; if (fwd_sel0 !== 2'd3) begin n_bad++; $display("FAIL br_bubbles: got %0d want 3", fwd_sel0); end
    $display("test_branch done");
  endtask

  task automatic test_freeze();
    do_reset();
    @(negedge clk); drive_id(0, 0, 0, 0, 3, 1, 1, 0);
    @(negedge clk); drive_id(3, 1, 4, 1, 7, 1, 0, 0); cache_stall = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++; if ({freeze, stall_front} !== 2'b11) begin n_bad++; $display("FAIL frz_hold%0d: got %b want 11", i, {freeze, stall_front}); end
    end
    @(negedge clk); cache_stall = 0; #1;
    n_cmp++; if ({freeze, stall_front} !== 2'b01) begin n_bad++; $display("FAIL frz_release: got %b want 01", {freeze, stall_front}); end
    @(negedge clk); #1;
    n_cmp++; if (stall_front !== 1'b0) begin n_bad++; $display("FAIL frz_resolve: got %b want 0", stall_front); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (fwd_sel0 !== 2'd2) begin n_bad++; $display("FAIL frz_fwd0: got %0d want 2", fwd_sel0); end
    $display("test_freeze done");
  endtask

  task automatic test_halt();
    do_reset();
    @(negedge clk); drive_id(0, 0, 0, 0, 0, 0, 0, 1); #1;
    n_cmp++; if (fetch_en !== 1'b1) begin n_bad++; $display("FAIL hlt_fetch0: got %b want 1", fetch_en); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); idle_inputs(); #1;
      n_cmp++; if ({fetch_en, halted} !== 2'b00) begin n_bad++; $display("FAIL hlt_drain%0d: got %b want 00", i, {fetch_en, halted}); end
    end
    @(negedge clk); #1;
    n_cmp++; if ({fetch_en, halted} !== 2'b01) begin n_bad++; $display("FAIL hlt_halted: got %b want 01", {fetch_en, halted}); end
    @(negedge clk); branch_taken = 1;
    @(negedge clk); branch_taken = 0; #1;
    n_cmp++; if ({fetch_en, halted} !== 2'b01) begin n_bad++; $display("FAIL hlt_sticky: got %b want 01", {fetch_en, halted}); end
    $display("test_halt done");
  endtask

  task automatic test_halt_branch();
    do_reset();
    @(negedge clk); drive_id(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); idle_inputs(); branch_taken = 1; #1;
    n_cmp++; if (fetch_en !== 1'b0) begin n_bad++; $display("FAIL hb_drain: got %b want 0", fetch_en); end
    @(negedge clk); branch_taken = 0; #1;
    n_cmp++; if (fetch_en !== 1'b1) begin n_bad++; $display("FAIL hb_run: got %b want 1", fetch_en); end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ({fetch_en, halted} !== 2'b10) begin n_bad++; $display("FAIL hb_nohalt: got %b want 10", {fetch_en, halted}); end
    $display("test_halt_branch done");
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    @(negedge clk); drive_id(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (fetch_en !== 1'b0) begin n_bad++; $display("FAIL rmd_drain: got %b want 0", fetch_en); end
    rst_n = 0; #1;
    n_cmp++; if ({fetch_en, halted} !== 2'b10) begin n_bad++; $display("FAIL rmd_async: got %b want 10", {fetch_en, halted}); end
    @(negedge clk); rst_n = 1;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++; if ({fetch_en, halted} !== 2'b10) begin n_bad++; $display("FAIL rmd_run: got %b want 10", {fetch_en, halted}); end
    $display("test_reset_mid_drain done");
  endtask

  function automatic int exp_fwd(input int s);
    // Select value equals the producer's age; a load one stage ahead cannot forward.
    if (s == 0) return 0;
    for (int a = 1; a <= 3; a++) begin
      if (hist[a].v && hist[a].we && hist[a].dst == s) begin
        if (!(a == 1 && hist[a].mre)) return a;
      end
    end
    return 0;
  endfunction

  task automatic test_random();
    ent_t n;
    bit   exp_stall;
    int   e0, e1;
    do_reset();
    hist.delete();
    for (int i = 0; i < 4; i++) hist.push_back('{default: 0});
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      idle_inputs();
      if ($urandom % 4 != 0) begin
        drive_id($urandom_range(0, 7), 1'($urandom % 2), $urandom_range(0, 7), 1'($urandom % 2),
                 $urandom_range(0, 7), 1'($urandom % 4 != 0), 1'($urandom % 3 == 0), 0);
        if (!id_reg_we) id_mem_re = 0;
      end
      branch_taken = ($urandom % 8 == 0);
      cache_stall  = ($urandom % 6 == 0);
      #1;
      exp_stall = hist[0].v && hist[0].mre && hist[0].we && hist[0].dst != 0 && id_valid &&
                  ((id_src0_used && int'(id_src0_addr) == hist[0].dst) ||
                   (id_src1_used && int'(id_src1_addr) == hist[0].dst)) && !branch_taken;
      e0 = exp_fwd(hist[0].s0);
      e1 = exp_fwd(hist[0].s1);
      $display("rnd %0d: v=%b s=%0d/%0d d=%0d br=%b cs=%b stall=%b fwd=%0d/%0d",
               c, id_valid, id_src0_addr, id_src1_addr, id_dst_addr, branch_taken, cache_stall,
               stall_front, fwd_sel0, fwd_sel1);
      n_cmp++; if (stall_front !== exp_stall) begin n_bad++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall_front, exp_stall); end
      n_cmp++; if ({flush_if_id, flush_id_ex} !== {2{branch_taken}}) begin n_bad++; $display("FAIL rnd_flush c%0d: got %b want %b", c, {flush_if_id, flush_id_ex}, {2{branch_taken}}); end
      n_cmp++; if (freeze !== cache_stall) begin n_bad++; $display("FAIL rnd_freeze c%0d: got %b want %b", c, freeze, cache_stall); end
      n_cmp++; if (int'(fwd_sel0) != e0 || $isunknown(fwd_sel0)) begin n_bad++; $display("FAIL rnd_fwd0 c%0d: got %0d want %0d", c, fwd_sel0, e0); end
      n_cmp++; if (int'(fwd_sel1) != e1 || $isunknown(fwd_sel1)) begin n_bad++; $display("FAIL rnd_fwd1 c%0d: got %0d want %0d", c, fwd_sel1, e1); end
      n_cmp++; if (fetch_en !== 1'b1) begin n_bad++; $display("FAIL rnd_fetch c%0d: got %b want 1", c, fetch_en); end
      if (!cache_stall) begin
        n = '{default: 0};
        if (id_valid && !branch_taken && !exp_stall) begin
          n.v = 1; n.dst = int'(id_dst_addr); n.we = id_reg_we; n.mre = id_mem_re;
          n.s0 = int'(id_src0_addr); n.s1 = int'(id_src1_addr);
        end
        hist.push_front(n);
        void'(hist.pop_back());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_fwd_wb1_r0();
    test_branch();
    test_freeze();
    test_halt();
    test_halt_branch();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
